// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants shared by the UART transmit/receive blocks and their
//               monitors: FSM state encoding, oversampling ratio and the
//               sub-bit tick indices used for majority-vote sampling.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Line FSM state encoding (also exported on state_bits)
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b11;
    localparam logic [1:0] ST_STOP  = 2'b10;

    // Oversample ticks per bit period
    localparam int OSR = 16;

    // Sub-bit tick indices of the three votes; the bit is decided on SMP_C
    localparam int SMP_A = 7;
    localparam int SMP_B = 8;
    localparam int SMP_C = 9;

    // Two-out-of-three vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               held in a register so dout is a flop output; pushing into a
//               FIFO that drains to one entry bypasses din straight to it.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr;
    logic [c_PTR_W-1:0] r_rd;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_dout;

    logic               w_pop;
    logic               w_push;
    logic [c_PTR_W-1:0] w_rd_nxt;
    logic [WIDTH-1:0]   w_dout_nxt;

    // A push into a full FIFO is only accepted when a pop frees a slot this cycle
    assign w_pop    = pop && (r_count != '0);
    assign w_push   = push && ((r_count != c_FULL) || w_pop);
    assign w_rd_nxt = r_rd + c_PTR_W'(1);

    // Next head value: following entry on pop, bypassed din when the slot behind the head is being written
    always_comb begin
        w_dout_nxt = r_dout;
        if (w_pop) begin
            if (r_count == c_ONE) begin
                if (w_push) begin
                    w_dout_nxt = din;
                end
            end else begin
                w_dout_nxt = r_mem[w_rd_nxt];
            end
        end else if (w_push && (r_count == '0)) begin
            w_dout_nxt = din;
        end
    end

    // Storage array, no reset needed since reads are gated by the occupancy count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= din;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            r_dout <= w_dout_nxt;
            if (w_push) begin
                r_wr <= r_wr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= w_rd_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_dout;
    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffered
// Description : 8N1 oversampling UART receiver with 3-sample majority vote,
//               framing/overrun pulses and a FWFT receive FIFO drained through
//               a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_RATE   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              rx,
    output logic [7:0]                        data_out,
    output logic                              data_valid,
    input  logic                              data_ready,
    output logic                              framing_err,
    output logic                              overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic [1:0]                        state_bits
);

    localparam int c_OSR_DIV = CLK_RATE / (BAUD_RATE * OSR);
    localparam int c_DIV_W   = (c_OSR_DIV > 1) ? $clog2(c_OSR_DIV) : 1;

    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    logic [c_DIV_W-1:0] r_div;
    logic [3:0]         r_sub;
    logic [1:0]         r_state;
    logic [2:0]         r_idx;
    logic               r_got;
    logic               r_brk;
    logic               r_s_a;
    logic               r_s_b;
    logic [7:0]         r_shift;
    logic               r_framing_err;
    logic               r_overrun;

    logic               w_start_edge;
    logic               w_tick;
    logic [3:0]         w_sub_inc;
    logic               w_dec;
    logic               w_bnd;
    logic               w_maj;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_push;

    assign w_start_edge = r_rx_prev & ~r_rx_sync;
    assign w_tick       = (r_div == c_DIV_W'(c_OSR_DIV - 1));
    assign w_sub_inc    = r_sub + 4'd1;
    // The edge itself is tick 0, so the votes straddle the bit centre
    assign w_dec        = w_tick && (w_sub_inc == 4'(SMP_C));
    assign w_bnd        = w_tick && (r_sub == 4'(OSR - 1));
    assign w_maj        = maj3(r_s_a, r_s_b, r_rx_sync);
    assign w_pop        = ~w_empty & data_ready;
    // A pop in the same cycle frees the slot a completed byte needs
    assign w_push       = (r_state == ST_STOP) && !r_brk && w_dec && w_maj && (!w_full || w_pop);

    // Two-flop synchronizer plus one delayed copy for start-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Free-running oversample divider, realigned to each start edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div <= '0;
        end else if (((r_state == ST_IDLE) && w_start_edge) || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    // Line FSM with sub-bit counter, vote capture, shift register and error pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_sub         <= 4'd0;
            r_idx         <= 3'd0;
            r_got         <= 1'b0;
            r_brk         <= 1'b0;
            r_s_a         <= 1'b1;
            r_s_b         <= 1'b1;
            r_shift       <= 8'd0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
            if (w_tick) begin
                r_sub <= w_sub_inc;
                if (w_sub_inc == 4'(SMP_A)) r_s_a <= r_rx_sync;
                if (w_sub_inc == 4'(SMP_B)) r_s_b <= r_rx_sync;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_state <= ST_START;
                        r_sub   <= 4'd0;
                    end
                end
                ST_START: begin
                    // A start bit that does not vote low is line noise
                    if (w_dec) begin
                        if (w_maj) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DATA;
                            r_idx   <= 3'd0;
                            r_got   <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    // r_got skips the boundary that closes the start bit
                    if (w_dec) begin
                        r_shift <= {w_maj, r_shift[7:1]};
                        r_got   <= 1'b1;
                    end else if (w_bnd && r_got) begin
                        r_got <= 1'b0;
                        if (r_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_brk   <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (r_brk) begin
                        // Break: wait for the line to recover before hunting again
                        if (r_rx_sync) begin
                            r_state <= ST_IDLE;
                            r_brk   <= 1'b0;
                        end
                    end else if (w_dec) begin
                        if (w_maj) begin
                            r_overrun <= w_full && !w_pop;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_framing_err <= 1'b1;
                            r_brk         <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .din   (r_shift),
        .pop   (w_pop),
        .dout  (data_out),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    assign data_valid  = ~w_empty;
    assign framing_err = r_framing_err;
    assign overrun     = r_overrun;
    assign state_bits  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_buffered
// Description : Directed testbench for uart_rx_buffered. The bench drives the
//               serial line itself at 64 clocks per bit (divider of 4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_buffered;

    localparam int BIT = 64;

    logic       clk        = 1'b0;
    logic       rstn       = 1'b0;
    logic       rx         = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       overrun;
    logic [3:0] fifo_count;
    logic [1:0] state_bits;

    int         total  = 0;
    int         bad    = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLK_RATE   (6400000),
        .BAUD_RATE  (100000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .framing_err (framing_err),
        .overrun     (overrun),
        .fifo_count  (fifo_count),
        .state_bits  (state_bits)
    );

    // Record popped bytes and error pulses half a cycle away from the active edge
    always @(negedge clk) begin
        if (rstn) begin
            if (data_valid && data_ready) got_q.push_back(data_out);
            if (framing_err) fe_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int per);
        hold(1'b0, per);
        for (int i = 0; i < 8; i++) hold(d[i], per);
        hold(1'b1, per);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_n"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_flags();
        fe_cnt = 0;
        ov_cnt = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] fb;

        // Reset values
        idle(3);
        check("rst_valid", data_valid, 0);
        check("rst_dout", data_out, 0);
        check("rst_count", fifo_count, 0);
        check("rst_state", state_bits, 2'b00);
        check("rst_fe", framing_err, 0);
        check("rst_ov", overrun, 0);
        rstn = 1'b1;
        idle(10);

        // Streaming reception with the consumer always ready
        clear_flags();
        data_ready = 1'b1;
        send(8'h55, BIT);
        send(8'hFF, BIT);
        send(8'h00, BIT);
        send(8'hA5, BIT);
        idle(20);
        exp_q = '{8'h55, 8'hFF, 8'h00, 8'hA5};
        check_rx("loop");
        check("loop_fe", fe_cnt, 0);
        check("loop_ov", ov_cnt, 0);

        // Fill past capacity with the consumer stalled
        clear_flags();
        data_ready = 1'b0;
        for (int b = 1; b <= 10; b++) send(8'(b), BIT);
        idle(20);
        check("ovr_count", fifo_count, 8);
        check("ovr_pulses", ov_cnt, 2);
        check("ovr_fe", fe_cnt, 0);
        check("ovr_head", data_out, 8'h01);
        data_ready = 1'b1;
        idle(20);
        data_ready = 1'b0;
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        check_rx("drain");
        check("drain_count", fifo_count, 0);

        // Short low glitch: false start
        clear_flags();
        hold(1'b0, 8);
        check("glitch_start", state_bits, 2'b01);
        hold(1'b0, 4);
        hold(1'b1, 2 * BIT);
        check("glitch_idle", state_bits, 2'b00);
        check("glitch_count", fifo_count, 0);
        check("glitch_fe", fe_cnt, 0);
        check("glitch_ov", ov_cnt, 0);

        // Frame 0x3C with stop bit held low for two bit periods
        clear_flags();
        data_ready = 1'b1;
        fb = 8'h3C;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(fb[i], BIT);
        hold(1'b0, BIT + BIT / 2);
        check("brk_state", state_bits, 2'b10);
        check("brk_fe", fe_cnt, 1);
        hold(1'b0, BIT / 2);
        check("brk_still", state_bits, 2'b10);
        hold(1'b1, BIT);
        check("brk_idle", state_bits, 2'b00);
        check("brk_count", fifo_count, 0);
        check("brk_valid", data_valid, 0);
        send(8'h81, BIT);
        idle(20);
        exp_q = '{8'h81};
        check_rx("after_brk");
        check("after_brk_fe", fe_cnt, 1);
        check("after_brk_ov", ov_cnt, 0);

        // Baud mismatch: +3% then -3%
        clear_flags();
        send(8'h12, 66);
        send(8'h34, 62);
        idle(20);
        exp_q = '{8'h12, 8'h34};
        check_rx("tol");
        check("tol_fe", fe_cnt, 0);
        check("tol_ov", ov_cnt, 0);

        // Asynchronous reset during a frame with bytes queued
        clear_flags();
        data_ready = 1'b0;
        send(8'h11, BIT);
        send(8'h22, BIT);
        idle(10);
        check("pre_rst_count", fifo_count, 2);
        fb = 8'h78;
        hold(1'b0, BIT);
        for (int i = 0; i < 3; i++) hold(fb[i], BIT);
        hold(fb[3], BIT / 2);
        check("pre_rst_state", state_bits, 2'b11);
        rstn = 1'b0;
        #2;
        check("arst_state", state_bits, 2'b00);
        check("arst_valid", data_valid, 0);
        check("arst_count", fifo_count, 0);
        check("arst_dout", data_out, 0);
        check("arst_fe", framing_err, 0);
        check("arst_ov", overrun, 0);
        rx = 1'b1;
        idle(5);
        rstn = 1'b1;
        idle(10);
        send(8'h9A, BIT);
        idle(10);
        check("post_rst_count", fifo_count, 1);
        check("post_rst_head", data_out, 8'h9A);
        data_ready = 1'b1;
        idle(5);
        exp_q = '{8'h9A};
        check_rx("post_rst");
        check("post_rst_empty", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
